// File: rtl/cl_manycore_pkg.sv
// Shared manycore host-link defaults and small width helpers.
package cl_manycore_pkg;

    localparam int host_word_width_gp = 32;
    localparam int mcl_fifo_width_gp  = 128;

    // Index width for a counter over n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_mcl_host_word_packer_rx.sv
// Receive side: small 1r1w packet FIFO, occupancy counter and word-index mux
// that presents the head packet to the host one word at a time.
module bsg_mcl_host_word_packer_rx
    import cl_manycore_pkg::*;
#(
    parameter int fifo_width_p     = mcl_fifo_width_gp,
    parameter int word_width_p     = host_word_width_gp,
    parameter int els_p            = 16,
    parameter int words_per_pkt_lp = fifo_width_p / word_width_p,
    parameter int count_w_lp       = $clog2(els_p + 1)
)(
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    enq_v_i,
    input  logic [fifo_width_p-1:0] enq_data_i,
    output logic                    enq_rdy_o,
    input  logic                    yumi_i,
    output logic                    v_o,
    output logic [word_width_p-1:0] word_o,
    output logic [count_w_lp-1:0]   count_o,
    output logic [count_w_lp-1:0]   vacancy_o
);

    localparam int ptr_w_lp = idx_width(els_p);
    localparam int idx_w_lp = idx_width(words_per_pkt_lp);
    localparam logic [idx_w_lp-1:0]   idx_last_lp = idx_w_lp'(words_per_pkt_lp - 1);
    localparam logic [count_w_lp-1:0] els_lp      = count_w_lp'(els_p);

    logic [fifo_width_p-1:0] mem_r [els_p];
    logic [ptr_w_lp-1:0]     wptr_r;
    logic [ptr_w_lp-1:0]     rptr_r;
    logic [count_w_lp-1:0]   count_r;
    logic [idx_w_lp-1:0]     idx_r;
    logic                    enq_s;
    logic                    yumi_s;
    logic                    deq_s;

    // Ready comes from the registered count only, so a full FIFO stays closed even while draining.
    always_comb begin
        enq_rdy_o = (count_r < els_lp);
        v_o       = (count_r != '0);
        enq_s     = enq_v_i && enq_rdy_o;
        yumi_s    = yumi_i && v_o;
        deq_s     = yumi_s && (idx_r == idx_last_lp);
        word_o    = mem_r[rptr_r][idx_r*word_width_p +: word_width_p];
        count_o   = count_r;
        vacancy_o = els_lp - count_r;
    end

    // Packet storage; stale contents are unreachable once the pointers reset.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_r[wptr_r] <= enq_data_i;
        end
    end

    // Pointers, occupancy and the word index within the head packet.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            idx_r   <= '0;
        end else begin
            if (enq_s) begin
                wptr_r <= wptr_r + ptr_w_lp'(1);
            end
            if (deq_s) begin
                rptr_r <= rptr_r + ptr_w_lp'(1);
                idx_r  <= '0;
            end else if (yumi_s) begin
                idx_r  <= idx_r + idx_w_lp'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + count_w_lp'(1);
                2'b01:   count_r <= count_r - count_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bsg_mcl_host_word_packer.sv
// Host word packer: assembles host words into bridge packets, and unpacks
// bridge packets buffered in a receive FIFO back into host words.
module bsg_mcl_host_word_packer
    import cl_manycore_pkg::*;
#(
    parameter int fifo_width_p     = mcl_fifo_width_gp,
    parameter int word_width_p     = host_word_width_gp,
    parameter int rcv_fifo_els_p   = 16,
    parameter int words_per_pkt_lp = fifo_width_p / word_width_p
)(
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               tx_v_i,
    input  logic [word_width_p-1:0]            tx_word_i,
    output logic                               tx_rdy_o,
    output logic                               pkt_v_o,
    output logic [fifo_width_p-1:0]            pkt_data_o,
    input  logic                               pkt_rdy_i,
    input  logic                               pkt_v_i,
    input  logic [fifo_width_p-1:0]            pkt_data_i,
    output logic                               pkt_rdy_o,
    output logic                               rx_v_o,
    output logic [word_width_p-1:0]            rx_word_o,
    input  logic                               rx_yumi_i,
    output logic [$clog2(rcv_fifo_els_p+1)-1:0] rx_vacancy_o,
    output logic [$clog2(rcv_fifo_els_p+1)-1:0] rx_count_o
);

    localparam int tx_cnt_w_lp = idx_width(words_per_pkt_lp);
    localparam logic [tx_cnt_w_lp-1:0] tx_last_lp = tx_cnt_w_lp'(words_per_pkt_lp - 1);

    logic [tx_cnt_w_lp-1:0]  tx_cnt_r;
    logic [fifo_width_p-1:0] tx_asm_r;
    logic [fifo_width_p-1:0] tx_merged_s;
    logic                    tx_last_s;
    logic                    tx_accept_s;
    logic                    tx_load_s;

    // The last word may only enter when the holding register is empty or draining this cycle.
    always_comb begin
        tx_last_s   = (tx_cnt_r == tx_last_lp);
        tx_rdy_o    = !(tx_last_s && pkt_v_o && !pkt_rdy_i);
        tx_accept_s = tx_v_i && tx_rdy_o;
        tx_load_s   = tx_accept_s && tx_last_s;
        tx_merged_s = tx_asm_r;
        tx_merged_s[tx_cnt_r*word_width_p +: word_width_p] = tx_word_i;
    end

    // Word counter, assembly buffer and registered packet holding stage.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            tx_cnt_r   <= '0;
            tx_asm_r   <= '0;
            pkt_v_o    <= 1'b0;
            pkt_data_o <= '0;
        end else begin
            if (tx_accept_s) begin
                tx_asm_r <= tx_merged_s;
                tx_cnt_r <= tx_last_s ? '0 : tx_cnt_r + tx_cnt_w_lp'(1);
            end
            if (tx_load_s) begin
                pkt_v_o    <= 1'b1;
                pkt_data_o <= tx_merged_s;
            end else if (pkt_rdy_i) begin
                pkt_v_o    <= 1'b0;
            end
        end
    end

    bsg_mcl_host_word_packer_rx #(
        .fifo_width_p (fifo_width_p),
        .word_width_p (word_width_p),
        .els_p        (rcv_fifo_els_p)
    ) rx (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_v_i    (pkt_v_i),
        .enq_data_i (pkt_data_i),
        .enq_rdy_o  (pkt_rdy_o),
        .yumi_i     (rx_yumi_i),
        .v_o        (rx_v_o),
        .word_o     (rx_word_o),
        .count_o    (rx_count_o),
        .vacancy_o  (rx_vacancy_o)
    );

endmodule

// File: tb/tb_bsg_mcl_host_word_packer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based reference model.
module tb_bsg_mcl_host_word_packer;

    localparam int N   = 4;
    localparam int ELS = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         tx_v;
    logic [31:0]  tx_word;
    logic         tx_rdy;
    logic         pkt_v_out;
    logic [127:0] pkt_data_out;
    logic         pkt_rdy_in;
    logic         pkt_v_in;
    logic [127:0] pkt_data_in;
    logic         pkt_rdy_out;
    logic         rx_v;
    logic [31:0]  rx_word;
    logic         rx_yumi;
    logic [4:0]   rx_vacancy;
    logic [4:0]   rx_count;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0]  m_tx_words[$];
    bit           m_hold_v;
    logic [127:0] m_hold_data;
    logic [127:0] m_rx_q[$];
    int           m_rx_pos;

    bsg_mcl_host_word_packer dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .tx_v_i       (tx_v),
        .tx_word_i    (tx_word),
        .tx_rdy_o     (tx_rdy),
        .pkt_v_o      (pkt_v_out),
        .pkt_data_o   (pkt_data_out),
        .pkt_rdy_i    (pkt_rdy_in),
        .pkt_v_i      (pkt_v_in),
        .pkt_data_i   (pkt_data_in),
        .pkt_rdy_o    (pkt_rdy_out),
        .rx_v_o       (rx_v),
        .rx_word_o    (rx_word),
        .rx_yumi_i    (rx_yumi),
        .rx_vacancy_o (rx_vacancy),
        .rx_count_o   (rx_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tx_words.delete();
        m_hold_v    = 1'b0;
        m_hold_data = '0;
        m_rx_q.delete();
        m_rx_pos    = 0;
    endtask

    task automatic check_outputs();
        logic [127:0] head;
        logic [31:0]  exp_word;
        bit           exp_tx_rdy;
        exp_tx_rdy = !((m_tx_words.size() == N-1) && m_hold_v && !pkt_rdy_in);
        check_eq("tx_rdy", tx_rdy, exp_tx_rdy);
        check_eq("pkt_v", pkt_v_out, m_hold_v);
        check_eq("pkt_data", pkt_data_out, m_hold_data);
        check_eq("pkt_rdy", pkt_rdy_out, m_rx_q.size() < ELS);
        check_eq("rx_v", rx_v, m_rx_q.size() > 0);
        check_eq("rx_count", rx_count, m_rx_q.size());
        check_eq("rx_vacancy", rx_vacancy, ELS - m_rx_q.size());
        if (m_rx_q.size() > 0) begin
            head     = m_rx_q[0];
            exp_word = head[m_rx_pos*32 +: 32];
            check_eq("rx_word", rx_word, exp_word);
        end
    endtask

    // Applies one clock edge worth of handshakes to the model, using pre-edge state.
    task automatic model_update();
        bit           tx_ok, drained, loaded, enq, deq_word;
        logic [127:0] pkt;
        tx_ok    = !((m_tx_words.size() == N-1) && m_hold_v && !pkt_rdy_in);
        drained  = m_hold_v && pkt_rdy_in;
        loaded   = 1'b0;
        enq      = pkt_v_in && (m_rx_q.size() < ELS);
        deq_word = rx_yumi && (m_rx_q.size() > 0);
        if (tx_v && tx_ok) begin
            m_tx_words.push_back(tx_word);
            if (m_tx_words.size() == N) begin
                pkt = '0;
                for (int k = 0; k < N; k++) pkt[k*32 +: 32] = m_tx_words[k];
                m_hold_data = pkt;
                m_hold_v    = 1'b1;
                loaded      = 1'b1;
                m_tx_words.delete();
            end
        end
        if (!loaded && drained) m_hold_v = 1'b0;
        if (deq_word) begin
            m_rx_pos++;
            if (m_rx_pos == N) begin
                void'(m_rx_q.pop_front());
                m_rx_pos = 0;
            end
        end
        if (enq) m_rx_q.push_back(pkt_data_in);
    endtask

    // Called at a negedge: drive, check, clock, update model, return at next negedge.
    task automatic step(input logic tv, input logic [31:0] tw, input logic pr,
                        input logic pv, input logic [127:0] pd, input logic yu);
        tx_v        = tv;
        tx_word     = tw;
        pkt_rdy_in  = pr;
        pkt_v_in    = pv;
        pkt_data_in = pd;
        rx_yumi     = yu && (m_rx_q.size() > 0);
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        tx_v        = 1'b0;
        tx_word     = '0;
        pkt_rdy_in  = 1'b0;
        pkt_v_in    = 1'b0;
        pkt_data_in = '0;
        rx_yumi     = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [31:0]  w [1:8];
        logic [127:0] rx_pkt;
        logic [31:0]  unpack_exp [4];

        do_reset();
        @(negedge clk);
        do_reset();

        // reset values
        check_eq("rst_pkt_v", pkt_v_out, 1'b0);
        check_eq("rst_pkt_data", pkt_data_out, 128'h0);
        check_eq("rst_tx_rdy", tx_rdy, 1'b1);
        check_eq("rst_pkt_rdy", pkt_rdy_out, 1'b1);
        check_eq("rst_rx_v", rx_v, 1'b0);
        check_eq("rst_rx_count", rx_count, 5'd0);
        check_eq("rst_rx_vacancy", rx_vacancy, 5'd16);

        // TX basic
        step(1'b1, 32'h11111111, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 32'h22222222, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 32'h33333333, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 32'h44444444, 1'b1, 1'b0, '0, 1'b0);
        check_eq("txb_v", pkt_v_out, 1'b1);
        check_eq("txb_data", pkt_data_out, 128'h44444444_33333333_22222222_11111111);
        step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0);
        check_eq("txb_pulse", pkt_v_out, 1'b0);

        // TX backpressure
        for (int i = 1; i <= 8; i++) w[i] = 32'hB0000000 | i;
        for (int i = 1; i <= 7; i++) step(1'b1, w[i], 1'b0, 1'b0, '0, 1'b0);
        check_eq("bp_hold_data", pkt_data_out, {w[4], w[3], w[2], w[1]});
        check_eq("bp_hold_v", pkt_v_out, 1'b1);
        tx_v = 1'b1; tx_word = w[8]; pkt_rdy_in = 1'b0;
        #1;
        check_eq("bp_tx_rdy_low", tx_rdy, 1'b0);
        step(1'b1, w[8], 1'b0, 1'b0, '0, 1'b0);
        check_eq("bp_still_held", pkt_data_out, {w[4], w[3], w[2], w[1]});
        pkt_rdy_in = 1'b1;
        #1;
        check_eq("bp_tx_rdy_comb", tx_rdy, 1'b1);
        step(1'b1, w[8], 1'b1, 1'b0, '0, 1'b0);
        check_eq("bp_second_v", pkt_v_out, 1'b1);
        check_eq("bp_second_data", pkt_data_out, {w[8], w[7], w[6], w[5]});
        step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0);

        // RX fill, then dequeue coinciding with an enqueue attempt while full
        for (int i = 0; i < ELS; i++) step(1'b0, 32'h0, 1'b1, 1'b1, rnd128(), 1'b0);
        check_eq("fill_pkt_rdy", pkt_rdy_out, 1'b0);
        check_eq("fill_count", rx_count, 5'd16);
        check_eq("fill_vacancy", rx_vacancy, 5'd0);
        for (int i = 0; i < N-1; i++) step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, rnd128(), 1'b1);
        check_eq("drain1_vacancy", rx_vacancy, 5'd1);
        check_eq("drain1_count", rx_count, 5'd15);
        check_eq("drain1_pkt_rdy", pkt_rdy_out, 1'b1);
        for (int i = 0; i < 15*N; i++) step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1);
        check_eq("drained_count", rx_count, 5'd0);

        // RX unpack order
        rx_pkt = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        unpack_exp[0] = 32'hAAAAAAAA; unpack_exp[1] = 32'hBBBBBBBB;
        unpack_exp[2] = 32'hCCCCCCCC; unpack_exp[3] = 32'hDDDDDDDD;
        step(1'b0, 32'h0, 1'b1, 1'b1, rx_pkt, 1'b0);
        check_eq("unpack_v", rx_v, 1'b1);
        for (int k = 0; k < N; k++) begin
            #1;
            check_eq("unpack_word", rx_word, unpack_exp[k]);
            step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1);
        end
        check_eq("unpack_count", rx_count, 5'd0);

        // simultaneous enqueue and last-word dequeue at count 5
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1, rnd128(), 1'b0);
        for (int i = 0; i < N-1; i++) step(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, rnd128(), 1'b1);
        check_eq("simul_count", rx_count, 5'd5);
        check_eq("simul_vacancy", rx_vacancy, 5'd11);

        // reset mid-operation
        step(1'b1, 32'hDEAD0001, 1'b0, 1'b1, rnd128(), 1'b0);
        step(1'b1, 32'hDEAD0002, 1'b0, 1'b1, rnd128(), 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, rnd128(), 1'b0);
        do_reset();
        check_eq("mrst_pkt_v", pkt_v_out, 1'b0);
        check_eq("mrst_pkt_data", pkt_data_out, 128'h0);
        check_eq("mrst_tx_rdy", tx_rdy, 1'b1);
        check_eq("mrst_rx_v", rx_v, 1'b0);
        check_eq("mrst_count", rx_count, 5'd0);
        check_eq("mrst_vacancy", rx_vacancy, 5'd16);
        check_eq("mrst_pkt_rdy", pkt_rdy_out, 1'b1);
        @(negedge clk);
        step(1'b1, 32'hC0000001, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 32'hC0000002, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 32'hC0000003, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 32'hC0000004, 1'b1, 1'b0, '0, 1'b0);
        check_eq("mrst_clean_v", pkt_v_out, 1'b1);
        check_eq("mrst_clean_data", pkt_data_out, 128'hC0000004_C0000003_C0000002_C0000001);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, rnd128(), $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
